// File: rtl/axis_err_inj_pkg.sv
// Shared types for the AXI4-Stream error injector: rule modes, rule FSM states
// and the configuration latched by each rule when it is armed.
package axis_err_inj_pkg;

  // Upper bounds for the latched configuration fields.
  // Instance widths must not exceed these.
  localparam int unsigned MAX_DATA_W  = 64;
  localparam int unsigned MAX_MATCH_W = 8;

  typedef enum logic [1:0] {
    MODE_OFF        = 2'd0,
    MODE_ONESHOT    = 2'd1,
    MODE_COUNT      = 2'd2,
    MODE_CONTINUOUS = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } rule_state_e;

  typedef struct packed {
    mode_e                  mode;
    logic [MAX_MATCH_W-1:0] match;
    logic [MAX_DATA_W-1:0]  mask;
  } rule_cfg_t;

endpackage

// File: rtl/axis_err_inj_rule.sv
// One injection rule: IDLE/ARMED/DONE FSM, configuration latched at arm time,
// and the remaining-hit counter used by ONESHOT and COUNT modes.
module axis_err_inj_rule
  import axis_err_inj_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MATCH_W = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm_i,
  input  logic               disarm_i,
  input  logic [1:0]         mode_i,
  input  logic [MATCH_W-1:0] match_i,
  input  logic [DATA_W-1:0]  mask_i,
  input  logic [CNT_W-1:0]   count_i,
  input  logic               hit_i,
  output logic               armed_o,
  output logic               done_o,
  output logic [MATCH_W-1:0] match_o,
  output logic [DATA_W-1:0]  mask_o
);

  rule_state_e      state_q, state_d;
  rule_cfg_t        cfg_q, cfg_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  mode_e            arm_mode;

  assign arm_mode = mode_e'(mode_i);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cfg_d   = cfg_q;
    rem_d   = rem_q;
    if (disarm_i) begin
      state_d = ST_IDLE;
    end else if (arm_i && arm_mode != MODE_OFF) begin
      cfg_d.mode  = arm_mode;
      cfg_d.match = MAX_MATCH_W'(match_i);
      cfg_d.mask  = MAX_DATA_W'(mask_i);
      rem_d       = (arm_mode == MODE_COUNT) ? count_i : CNT_W'(1);
      // A zero count has nothing to inject, so skip straight to DONE.
      state_d     = (arm_mode == MODE_COUNT && count_i == '0) ? ST_DONE : ST_ARMED;
    end else if (state_q == ST_ARMED && hit_i && cfg_q.mode != MODE_CONTINUOUS) begin
      rem_d = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) state_d = ST_DONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      rem_q   <= rem_d;
    end
  end

  assign armed_o = (state_q == ST_ARMED);
  assign done_o  = (state_q == ST_DONE);
  assign match_o = cfg_q.match[MATCH_W-1:0];
  assign mask_o  = cfg_q.mask[DATA_W-1:0];

endmodule

// File: rtl/axis_err_injector.sv
// AXI4-Stream bit-error injector: one register stage with full backpressure;
// beats whose header matches an armed rule are XORed with that rule's mask.
module axis_err_injector
  import axis_err_inj_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MATCH_LSB = 56,
  parameter int unsigned MATCH_W   = 8,
  parameter int unsigned NUM_RULES = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [DATA_W-1:0]            s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  output logic [DATA_W-1:0]            m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  input  logic [NUM_RULES-1:0]         rule_arm,
  input  logic [NUM_RULES-1:0]         rule_disarm,
  input  logic [2*NUM_RULES-1:0]       rule_mode,
  input  logic [MATCH_W*NUM_RULES-1:0] rule_match,
  input  logic [DATA_W*NUM_RULES-1:0]  rule_mask,
  input  logic [CNT_W*NUM_RULES-1:0]   rule_count,
  output logic [NUM_RULES-1:0]         rule_armed,
  output logic [NUM_RULES-1:0]         rule_done,
  output logic [CNT_W-1:0]             inject_cnt
);

  logic                 xfer;
  logic [MATCH_W-1:0]   hdr;
  logic [NUM_RULES-1:0] hit;
  logic [DATA_W-1:0]    inj_mask;
  logic [MATCH_W-1:0]   r_match [NUM_RULES];
  logic [DATA_W-1:0]    r_mask  [NUM_RULES];

  logic                 m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0]    m_tdata_q, m_tdata_d;
  logic [CNT_W-1:0]     inject_cnt_q, inject_cnt_d;

  // The stage can accept whenever it is empty or draining this cycle.
  assign s_tready = ~m_tvalid_q | m_tready;
  assign xfer     = s_tvalid & s_tready;
  assign hdr      = s_tdata[MATCH_LSB +: MATCH_W];

  for (genvar i = 0; i < NUM_RULES; i++) begin : g_rule
    axis_err_inj_rule #(
      .DATA_W  (DATA_W),
      .MATCH_W (MATCH_W),
      .CNT_W   (CNT_W)
    ) u_rule (
      .clk      (aclk),
      .rst_n    (aresetn),
      .arm_i    (rule_arm[i]),
      .disarm_i (rule_disarm[i]),
      .mode_i   (rule_mode[2*i +: 2]),
      .match_i  (rule_match[MATCH_W*i +: MATCH_W]),
      .mask_i   (rule_mask[DATA_W*i +: DATA_W]),
      .count_i  (rule_count[CNT_W*i +: CNT_W]),
      .hit_i    (hit[i]),
      .armed_o  (rule_armed[i]),
      .done_o   (rule_done[i]),
      .match_o  (r_match[i]),
      .mask_o   (r_mask[i])
    );

    assign hit[i] = xfer & rule_armed[i] & (hdr == r_match[i]);
  end

  always_comb begin
    inj_mask = '0;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (hit[i]) inj_mask = inj_mask | r_mask[i];
    end
  end

  always_comb begin
    m_tvalid_d   = m_tvalid_q;
    m_tdata_d    = m_tdata_q;
    inject_cnt_d = inject_cnt_q;
    if (xfer) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = s_tdata ^ inj_mask;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end
    // One count per corrupted beat regardless of how many rules hit it.
    if (|hit && inject_cnt_q != '1) inject_cnt_d = inject_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid_q   <= 1'b0;
      // NOTE: the data register is reset too so m_tdata reads zero out of reset.
      m_tdata_q    <= '0;
      inject_cnt_q <= '0;
    end else begin
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      inject_cnt_q <= inject_cnt_d;
    end
  end

  assign m_tvalid   = m_tvalid_q;
  assign m_tdata    = m_tdata_q;
  assign inject_cnt = inject_cnt_q;

endmodule

// File: tb/tb_axis_err_injector.sv
// Directed bench for axis_err_injector: pass-through scoreboard, rule modes,
// overlap, backpressure, arm/disarm corner cases and async reset.
module tb_axis_err_injector;

  localparam int DATA_W    = 64;
  localparam int MATCH_W   = 8;
  localparam int NUM_RULES = 4;
  localparam int CNT_W     = 16;

  localparam logic [1:0] M_ONESHOT = 2'd1;
  localparam logic [1:0] M_COUNT   = 2'd2;
  localparam logic [1:0] M_CONT    = 2'd3;

  logic                         aclk = 1'b0;
  logic                         aresetn;
  logic [DATA_W-1:0]            s_tdata;
  logic                         s_tvalid;
  logic                         s_tready;
  logic [DATA_W-1:0]            m_tdata;
  logic                         m_tvalid;
  logic                         m_tready;
  logic [NUM_RULES-1:0]         rule_arm;
  logic [NUM_RULES-1:0]         rule_disarm;
  logic [2*NUM_RULES-1:0]       rule_mode;
  logic [MATCH_W*NUM_RULES-1:0] rule_match;
  logic [DATA_W*NUM_RULES-1:0]  rule_mask;
  logic [CNT_W*NUM_RULES-1:0]   rule_count;
  logic [NUM_RULES-1:0]         rule_armed;
  logic [NUM_RULES-1:0]         rule_done;
  logic [CNT_W-1:0]             inject_cnt;

  int checks = 0;
  int errors = 0;

  axis_err_injector #(
    .DATA_W    (DATA_W),
    .MATCH_LSB (56),
    .MATCH_W   (MATCH_W),
    .NUM_RULES (NUM_RULES),
    .CNT_W     (CNT_W)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .rule_arm    (rule_arm),
    .rule_disarm (rule_disarm),
    .rule_mode   (rule_mode),
    .rule_match  (rule_match),
    .rule_mask   (rule_mask),
    .rule_count  (rule_count),
    .rule_armed  (rule_armed),
    .rule_done   (rule_done),
    .inject_cnt  (inject_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_cfg();
    rule_mode  = '0;
    rule_match = '0;
    rule_mask  = '0;
    rule_count = '0;
  endtask

  task automatic set_cfg(input int idx, input logic [1:0] mode, input logic [7:0] match,
                         input logic [63:0] mask, input logic [15:0] cnt);
    rule_mode[2*idx +: 2]   = mode;
    rule_match[8*idx +: 8]  = match;
    rule_mask[64*idx +: 64] = mask;
    rule_count[16*idx +: 16] = cnt;
  endtask

  // Config is cleared right after the pulse, so later behaviour relies on latching.
  task automatic arm(input int idx, input logic [1:0] mode, input logic [7:0] match,
                     input logic [63:0] mask, input logic [15:0] cnt);
    set_cfg(idx, mode, match, mask, cnt);
    rule_arm[idx] = 1'b1;
    tick();
    rule_arm = '0;
    clear_cfg();
  endtask

  task automatic send(input logic [63:0] data);
    s_tdata  = data;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [63:0] exp);
    check({tag, "_valid"}, 64'(m_tvalid), 64'h1);
    check({tag, "_data"}, m_tdata, exp);
  endtask

  initial begin
    logic [63:0] q[$];
    int accepted;
    int cycles;
    int unstable;

    aresetn     = 1'b0;
    s_tdata     = '0;
    s_tvalid    = 1'b0;
    m_tready    = 1'b1;
    rule_arm    = '0;
    rule_disarm = '0;
    clear_cfg();
    #23 aresetn = 1'b1;
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'h0);
    check("rst_m_tdata", m_tdata, 64'h0);
    check("rst_s_tready", 64'(s_tready), 64'h1);
    check("rst_armed", 64'(rule_armed), 64'h0);
    check("rst_done", 64'(rule_done), 64'h0);
    check("rst_inject", 64'(inject_cnt), 64'h0);
    tick();

    // Random pass-through with random backpressure, no rules armed.
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 10000) begin
      s_tvalid = 1'($urandom_range(0, 1));
      s_tdata  = {$urandom, $urandom};
      m_tready = ($urandom_range(0, 3) != 0);
      @(negedge aclk);
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) check("t1_extra_beat", 64'(q.size()), 64'h1);
        else check("t1_data", m_tdata, q.pop_front());
      end
      if (s_tvalid && s_tready) begin
        q.push_back(s_tdata);
        accepted++;
      end
      tick();
      cycles++;
    end
    check("t1_accepted", 64'(accepted), 64'd1000);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge aclk);
      if (m_tvalid) check("t1_drain", m_tdata, q.pop_front());
      tick();
    end
    check("t1_drained", 64'(q.size()), 64'h0);
    check("t1_inject", 64'(inject_cnt), 64'h0);

    // ONESHOT
    arm(0, M_ONESHOT, 8'h2D, 64'h1, 16'h0);
    check("t2_armed", 64'(rule_armed), 64'h1);
    send(64'h2D00_0000_0000_1000);
    check_out("t2_b0", 64'h2D00_0000_0000_1001);
    check("t2_done", 64'(rule_done), 64'h1);
    check("t2_disarmed", 64'(rule_armed), 64'h0);
    send(64'h2D00_0000_0000_2000);
    check_out("t2_b1", 64'h2D00_0000_0000_2000);
    send(64'h2D11_2233_4455_6677);
    check_out("t2_b2", 64'h2D11_2233_4455_6677);
    check("t2_inject", 64'(inject_cnt), 64'd1);

    // COUNT = 3
    arm(1, M_COUNT, 8'hA7, 64'h3, 16'd3);
    check("t3_armed", 64'(rule_armed), 64'h2);
    send(64'hA700_0000_0000_0000);
    check_out("t3_b0", 64'hA700_0000_0000_0003);
    send(64'hA700_0000_0000_0004);
    check_out("t3_b1", 64'hA700_0000_0000_0007);
    check("t3_not_done_yet", 64'(rule_done), 64'h1);
    send(64'hA700_0000_0000_0008);
    check_out("t3_b2", 64'hA700_0000_0000_000B);
    check("t3_done", 64'(rule_done), 64'h3);
    send(64'hA700_0000_0000_000C);
    check_out("t3_b3", 64'hA700_0000_0000_000C);
    send(64'hA700_0000_0000_00FF);
    check_out("t3_b4", 64'hA700_0000_0000_00FF);
    check("t3_inject", 64'(inject_cnt), 64'd4);

    // Overlapping CONTINUOUS rules OR their masks
    arm(0, M_CONT, 8'h1B, 64'h1, 16'h0);
    arm(2, M_CONT, 8'h1B, 64'h2, 16'h0);
    check("t4_armed", 64'(rule_armed), 64'h5);
    check("t4_rearm_clears_done", 64'(rule_done), 64'h2);
    send(64'h1B00_0000_0000_00F0);
    check_out("t4_b0", 64'h1B00_0000_0000_00F3);
    send(64'h1B00_0000_0000_0003);
    check_out("t4_b1", 64'h1B00_0000_0000_0000);
    send(64'h1C00_0000_0000_00F0);
    check_out("t4_nomatch", 64'h1C00_0000_0000_00F0);
    check("t4_inject", 64'(inject_cnt), 64'd6);
    check("t4_still_armed", 64'(rule_armed), 64'h5);

    // Backpressure: stalled beat stays stable and is injected once
    tick();
    check("t5_idle", 64'(m_tvalid), 64'h0);
    s_tdata  = 64'h1BAA_0000_0000_0010;
    s_tvalid = 1'b1;
    m_tready = 1'b0;
    tick();
    s_tdata  = 64'h1BBB_0000_0000_0020;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (m_tdata !== 64'h1BAA_0000_0000_0013 || m_tvalid !== 1'b1 || s_tready !== 1'b0)
        unstable++;
      tick();
    end
    check("t5_unstable_cycles", 64'(unstable), 64'h0);
    check("t5_s_tready", 64'(s_tready), 64'h0);
    check("t5_inject", 64'(inject_cnt), 64'd7);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    @(negedge aclk);
    check_out("t5_release", 64'h1BAA_0000_0000_0013);
    tick();
    check("t5_delivered", 64'(m_tvalid), 64'h0);
    check("t5_inject_after", 64'(inject_cnt), 64'd7);

    // Arm in the same cycle as a matching beat: beat passes clean
    set_cfg(3, M_ONESHOT, 8'h5A, 64'hFF00, 16'h0);
    rule_arm[3] = 1'b1;
    s_tdata     = 64'h5A00_0000_0000_0001;
    s_tvalid    = 1'b1;
    m_tready    = 1'b1;
    tick();
    rule_arm = '0;
    s_tvalid = 1'b0;
    clear_cfg();
    check_out("t6_arm_cycle", 64'h5A00_0000_0000_0001);
    check("t6_armed", 64'(rule_armed), 64'hD);
    send(64'h5A00_0000_0000_0001);
    check_out("t6_after_arm", 64'h5A00_0000_0000_FF01);
    check("t6_done", 64'(rule_done), 64'hA);
    check("t6_inject", 64'(inject_cnt), 64'd8);

    // Hit and disarm together: beat corrupted, rules go IDLE
    rule_disarm = 4'b0101;
    send(64'h1B00_0000_0000_0000);
    rule_disarm = '0;
    check_out("t6_hit_disarm", 64'h1B00_0000_0000_0003);
    check("t6_hd_armed", 64'(rule_armed), 64'h0);
    check("t6_hd_inject", 64'(inject_cnt), 64'd9);

    // Disarm wins over a same-cycle arm
    set_cfg(1, M_ONESHOT, 8'hA7, 64'h1, 16'h0);
    rule_arm[1]    = 1'b1;
    rule_disarm[1] = 1'b1;
    tick();
    rule_arm    = '0;
    rule_disarm = '0;
    clear_cfg();
    check("t6_dis_arm_armed", 64'(rule_armed), 64'h0);
    check("t6_dis_arm_done", 64'(rule_done), 64'h8);

    // COUNT with zero count goes DONE with no injection
    arm(1, M_COUNT, 8'hA7, 64'h3, 16'd0);
    check("t6_cnt0_done", 64'(rule_done), 64'hA);
    check("t6_cnt0_armed", 64'(rule_armed), 64'h0);
    send(64'hA700_0000_0000_0000);
    check_out("t6_cnt0_beat", 64'hA700_0000_0000_0000);
    check("t6_cnt0_inject", 64'(inject_cnt), 64'd9);

    // Async reset with a beat held in the stage
    arm(2, M_CONT, 8'h1B, 64'h2, 16'h0);
    s_tdata  = 64'h1B00_0000_0000_00F0;
    s_tvalid = 1'b1;
    m_tready = 1'b0;
    tick();
    check_out("t6_pre_reset", 64'h1B00_0000_0000_00F2);
    check("t6_pre_reset_inject", 64'(inject_cnt), 64'd10);
    #2 aresetn = 1'b0;
    #1;
    check("t6_rst_m_tvalid", 64'(m_tvalid), 64'h0);
    check("t6_rst_m_tdata", m_tdata, 64'h0);
    check("t6_rst_s_tready", 64'(s_tready), 64'h1);
    check("t6_rst_armed", 64'(rule_armed), 64'h0);
    check("t6_rst_done", 64'(rule_done), 64'h0);
    check("t6_rst_inject", 64'(inject_cnt), 64'h0);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    aresetn  = 1'b1;
    tick();
    check("t6_post_rst_valid", 64'(m_tvalid), 64'h0);
    check("t6_post_rst_armed", 64'(rule_armed), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
